// File: rtl/servo_pkg.sv
// Shared definitions for the servo controller: FSM state encoding,
// default instruction width and opcode values used by the dispatcher.
package servo_pkg;

  localparam int WORD_W = 10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [1:0] OP_TURN    = 2'b01;
  localparam logic [1:0] OP_EXTEND  = 2'b10;
  localparam logic [1:0] OP_RETRACT = 2'b11;

endpackage

// File: rtl/serial_instr_receiver_if.sv
// Parallel instruction handshake between the serial receiver (master)
// and the instruction consumer (slave).
interface serial_instr_receiver_if
  import servo_pkg::*;
#(
  parameter int WORD_W = servo_pkg::WORD_W
);

  logic              instr_valid;
  logic [WORD_W-1:0] instr_data;
  logic              instr_ack;

  modport master (
    output instr_valid,
    output instr_data,
    input  instr_ack
  );

  modport slave (
    input  instr_valid,
    input  instr_data,
    output instr_ack
  );

endinterface

// File: rtl/serial_instr_receiver_strobe_filter.sv
// Synchronises an asynchronous strobe and emits a single accept pulse once
// the synchronised level has been high for CONF_FILTER consecutive cycles.
module strobe_filter
  import servo_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CONF_FILTER = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic strobe
);

  localparam int CNT_W = $clog2(CONF_FILTER + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign level = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
  end

  // Saturating count of consecutive high samples; strobe on the cycle it reaches the threshold.
  always_comb begin
    cnt_d  = cnt_q;
    strobe = 1'b0;
    if (!level) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(CONF_FILTER)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(CONF_FILTER - 1)) begin
        strobe = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_instr_receiver.sv
// Receives a bit-serial servo instruction (MSB first) on command/confirm,
// presents it as a parallel word with a valid/ack handshake, and flags
// inter-bit timeouts and overruns on frame_error.
module serial_instr_receiver
  import servo_pkg::*;
#(
  parameter int WORD_W         = servo_pkg::WORD_W,
  parameter int SYNC_STAGES    = 2,
  parameter int CONF_FILTER    = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    command,
  input  logic                    confirm,
  serial_instr_receiver_if.master instr_bus,
  output logic                    data_ready,
  output logic                    frame_error,
  output logic [1:0]              state_dbg
);

  localparam int BCNT_W = $clog2(WORD_W + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] cmd_sync_q, cmd_sync_d;
  logic                   cmd_s;
  logic                   conf_level;
  logic                   accept;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              data_ready_q, data_ready_d;
  logic              frame_err_q, frame_err_d;

  assign cmd_s = cmd_sync_q[SYNC_STAGES-1];

  strobe_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .CONF_FILTER (CONF_FILTER)
  ) u_confirm_filter (
    .clk      (clk),
    .reset    (reset),
    .async_in (confirm),
    .level    (conf_level),
    .strobe   (accept)
  );

  // Plain synchroniser for the serial data line.
  always_comb begin
    cmd_sync_d = {cmd_sync_q[SYNC_STAGES-2:0], command};
  end

  // Frame FSM: collect bits, publish the word, hold it until acknowledged.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d   = {shift_q[WORD_W-3:0], cmd_s};
          bit_cnt_d = BCNT_W'(1);
          to_cnt_d  = '0;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (accept) begin
          shift_d  = {shift_q[WORD_W-3:0], cmd_s};
          to_cnt_d = '0;
          if (bit_cnt_q == BCNT_W'(WORD_W - 1)) begin
            data_d    = {shift_q, cmd_s};
            valid_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          to_cnt_d    = '0;
          state_d     = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      HOLD: begin
        if (accept) begin
          frame_err_d = 1'b1;
        end
        if (instr_bus.instr_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    data_ready_d = (state_d != HOLD);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_sync_q   <= '0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cmd_sync_q   <= cmd_sync_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      data_ready_q <= data_ready_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign instr_bus.instr_valid = valid_q;
  assign instr_bus.instr_data  = data_q;
  assign data_ready            = data_ready_q;
  assign frame_error           = frame_err_q;
  assign state_dbg             = state_q;

endmodule

// File: tb/tb_serial_instr_receiver.sv
// Self-checking bench for serial_instr_receiver: table-driven frames,
// hand-written corner sequences and randomised frames against a pulse-level model.
module tb_serial_instr_receiver;
  import servo_pkg::*;

  localparam int W    = 10;
  localparam int CF   = 4;
  localparam int TOC  = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       command;
  logic       confirm;
  logic       data_ready;
  logic       frame_error;
  logic [1:0] state_dbg;

  int total    = 0;
  int bad      = 0;
  int fe_count = 0;

  serial_instr_receiver_if #(.WORD_W(W)) bus ();

  serial_instr_receiver #(
    .WORD_W         (W),
    .SYNC_STAGES    (2),
    .CONF_FILTER    (CF),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .command     (command),
    .confirm     (confirm),
    .instr_bus   (bus.master),
    .data_ready  (data_ready),
    .frame_error (frame_error),
    .state_dbg   (state_dbg)
  );

  typedef struct {
    logic [W-1:0] word;
    logic         glitch;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  // Count every cycle frame_error is high, sampled shortly after the edge.
  always begin
    @(posedge clk);
    #2;
    if (frame_error === 1'b1) fe_count++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendBit(input logic b, input int hi, input int lo);
    command = b;
    @(negedge clk);
    confirm = 1'b1;
    repeat (hi) @(negedge clk);
    confirm = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic glitchPulse(input int len);
    confirm = 1'b1;
    repeat (len) @(negedge clk);
    confirm = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [W-1:0] word, input logic glitch, input int nbits);
    for (int i = W - 1; i >= W - nbits; i--) begin
      if (glitch) glitchPulse(CF - 1);
      sendBit(word[i], 10, 10);
    end
  endtask

  task automatic waitValid(input string name, input int budget);
    for (int c = 0; c < budget && bus.instr_valid !== 1'b1; c++) @(negedge clk);
    checkOutput(name, bus.instr_valid, 1);
  endtask

  task automatic doAck();
    bus.instr_ack = 1'b1;
    @(negedge clk);
    bus.instr_ack = 1'b0;
    checkOutput("ack_valid_low", bus.instr_valid, 0);
    checkOutput("ack_ready_high", data_ready, 1);
    checkOutput("ack_state_idle", state_dbg, 0);
  endtask

  initial begin
    int fe0;
    logic [W-1:0] held;
    logic [W-1:0] rword;
    logic [W-1:0] model_word;
    logic         model_q[$];
    int           extra;

    vecs[0] = '{10'b01_1000_0000, 1'b0, 10'h180};
    vecs[1] = '{10'b11_0000_0000, 1'b1, 10'h300};
    vecs[2] = '{10'b10_1111_1111, 1'b0, 10'h2FF};
    vecs[3] = '{10'b01_0101_0101, 1'b1, 10'h155};
    vecs[4] = '{10'b11_1111_1111, 1'b0, 10'h3FF};
    vecs[5] = '{10'b00_0000_0001, 1'b0, 10'h001};
    vecs[6] = '{10'b10_1010_1010, 1'b1, 10'h2AA};

    reset = 1'b0;
    command = 1'b0;
    confirm = 1'b0;
    bus.instr_ack = 1'b0;
    #1;
    checkOutput("rst_valid", bus.instr_valid, 0);
    checkOutput("rst_data", bus.instr_data, 0);
    checkOutput("rst_ready", data_ready, 0);
    checkOutput("rst_fe", frame_error, 0);
    checkOutput("rst_state", state_dbg, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rel_ready_before_edge", data_ready, 0);
    @(negedge clk);
    checkOutput("rel_ready_after_edge", data_ready, 1);

    // Table-driven full frames, some with sub-threshold confirm glitches.
    for (int v = 0; v < 7; v++) begin
      fe0 = fe_count;
      applyStimulus(vecs[v].word, vecs[v].glitch, W);
      waitValid("tbl_valid", 20);
      checkOutput("tbl_data", bus.instr_data, vecs[v].exp_data);
      checkOutput("tbl_ready_low", data_ready, 0);
      checkOutput("tbl_state_hold", state_dbg, 2);
      checkOutput("tbl_no_fe", fe_count - fe0, 0);
      doAck();
      checkOutput("tbl_data_retained", bus.instr_data, vecs[v].exp_data);
    end

    // Inter-bit timeout discards a partial frame.
    held = bus.instr_data;
    fe0 = fe_count;
    applyStimulus(10'h3C5, 1'b0, 4);
    checkOutput("to_state_recv", state_dbg, 1);
    repeat (150) @(negedge clk);
    checkOutput("to_fe_once", fe_count - fe0, 1);
    checkOutput("to_state_idle", state_dbg, 0);
    checkOutput("to_valid_low", bus.instr_valid, 0);
    checkOutput("to_data_kept", bus.instr_data, held);
    checkOutput("to_ready", data_ready, 1);
    applyStimulus(10'b10_1111_1111, 1'b0, W);
    waitValid("to_next_valid", 20);
    checkOutput("to_next_data", bus.instr_data, 10'h2FF);

    // Overrun: extra pulses while holding are dropped and flagged.
    doAck();
    applyStimulus(10'h1C3, 1'b0, W);
    waitValid("ovr_valid", 20);
    fe0 = fe_count;
    sendBit(1'b0, 8, 6);
    sendBit(1'b1, 8, 6);
    checkOutput("ovr_fe_two", fe_count - fe0, 2);
    checkOutput("ovr_data_kept", bus.instr_data, 10'h1C3);
    checkOutput("ovr_valid_kept", bus.instr_valid, 1);
    doAck();

    // Ack in the same cycle as an overrun accept.
    applyStimulus(10'h0F0, 1'b0, W);
    waitValid("col_valid", 20);
    fe0 = fe_count;
    command = 1'b1;
    @(negedge clk);
    confirm = 1'b1;
    repeat (5) @(negedge clk);
    bus.instr_ack = 1'b1;
    @(negedge clk);
    bus.instr_ack = 1'b0;
    checkOutput("col_valid_low", bus.instr_valid, 0);
    checkOutput("col_fe_now", frame_error, 1);
    checkOutput("col_ready", data_ready, 1);
    repeat (4) @(negedge clk);
    confirm = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("col_fe_once", fe_count - fe0, 1);
    checkOutput("col_state_idle", state_dbg, 0);
    applyStimulus(10'h2A5, 1'b0, W);
    waitValid("col_next_valid", 20);
    checkOutput("col_next_data", bus.instr_data, 10'h2A5);
    doAck();

    // Reset mid-frame loses the partial word.
    applyStimulus(10'h3F0, 1'b0, 6);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", bus.instr_valid, 0);
    checkOutput("mid_rst_data", bus.instr_data, 0);
    checkOutput("mid_rst_ready", data_ready, 0);
    checkOutput("mid_rst_state", state_dbg, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rel_ready", data_ready, 1);
    applyStimulus(10'h155, 1'b0, W);
    waitValid("mid_next_valid", 20);
    checkOutput("mid_next_data", bus.instr_data, 10'h155);
    doAck();

    // Randomised frames: a pulse carries a bit only if it stays high CF cycles or more.
    for (int f = 0; f < 6; f++) begin
      model_q.delete();
      fe0 = fe_count;
      rword = W'($urandom);
      for (int i = W - 1; i >= 0; i--) begin
        if ($urandom_range(0, 1) == 1) begin
          command = 1'($urandom);
          glitchPulse($urandom_range(1, CF - 1));
        end
        sendBit(rword[i], $urandom_range(CF, 12), $urandom_range(4, 12));
        model_q.push_back(rword[i]);
      end
      model_word = '0;
      foreach (model_q[k]) model_word = {model_word[W-2:0], model_q[k]};
      waitValid("rnd_valid", 20);
      checkOutput("rnd_data", bus.instr_data, model_word);
      checkOutput("rnd_no_fe", fe_count - fe0, 0);
      extra = $urandom_range(0, 2);
      fe0 = fe_count;
      for (int e = 0; e < extra; e++) sendBit(1'($urandom), $urandom_range(CF, 8), 5);
      checkOutput("rnd_ovr_fe", fe_count - fe0, extra);
      checkOutput("rnd_ovr_data", bus.instr_data, model_word);
      doAck();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
